// File: rtl/demux_addr_scanner_pkg.sv
// rtl/demux_addr_scanner_pkg.sv - shared state encoding, widths and timing derivations
package demux_addr_scanner_pkg;

  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    AUTO_RUN   = 2'd1,
    AUTO_PAUSE = 2'd2
  } state_t;

  function automatic int deb_cycles(input int clk_hz, input int deb_ms);
    return clk_hz / 1000 * deb_ms;
  endfunction

  // Caller must keep the result >= 2 so the prescaler has a real period
  function automatic int step_div(input int clk_hz, input int step_hz);
    return clk_hz / step_hz;
  endfunction

endpackage

// File: rtl/demux_addr_scanner_if.sv
// rtl/demux_addr_scanner_if.sv - board input / demux output bundle
interface demux_addr_scanner_if;
  import demux_addr_scanner_pkg::*;

  logic              btn_step;
  logic              sw_auto;
  logic              sw_dir;
  logic              sw_d;
  logic [ADDR_W-1:0] addr;
  logic              d_out;
  logic              step_pulse;

  modport master (
    output btn_step, sw_auto, sw_dir, sw_d,
    input  addr, d_out, step_pulse
  );

  modport slave (
    input  btn_step, sw_auto, sw_dir, sw_d,
    output addr, d_out, step_pulse
  );

endinterface

// File: rtl/demux_addr_scanner_btn_debounce.sv
// rtl/demux_addr_scanner_btn_debounce.sv - 2-flop sync, stable-time debounce, one-cycle press pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int                CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             r_press;

  // Press is raised in the same edge that the debounced level rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (r_sync[1] == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_db    <= r_sync[1];
        r_press <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/demux_addr_scanner.sv
// rtl/demux_addr_scanner.sv - manual/auto address stepper driving the 8-way demux select and data
module demux_addr_scanner
  import demux_addr_scanner_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int DEB_MS  = 10,
  parameter int STEP_HZ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_addr_scanner_if.slave  bus
);

  localparam int              DEB_CYCLES = deb_cycles(CLK_HZ, DEB_MS);
  localparam int              STEP_DIV   = step_div(CLK_HZ, STEP_HZ);
  localparam int              PRE_W      = $clog2(STEP_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(STEP_DIV - 1);

  logic [1:0]        r_sync_auto;
  logic [1:0]        r_sync_dir;
  logic [1:0]        r_sync_d;
  state_t            r_state;
  logic [PRE_W-1:0]  r_pre;
  logic [ADDR_W-1:0] r_addr;
  logic              r_d_out;
  logic              r_step_pulse;

  logic w_press;
  logic w_tick;
  logic w_step;
  logic w_auto;
  logic w_dir;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.btn_step),
    .o_press (w_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_auto <= 2'b00;
      r_sync_dir  <= 2'b00;
      r_sync_d    <= 2'b00;
    end else begin
      r_sync_auto <= {r_sync_auto[0], bus.sw_auto};
      r_sync_dir  <= {r_sync_dir[0],  bus.sw_dir};
      r_sync_d    <= {r_sync_d[0],    bus.sw_d};
    end
  end

  assign w_auto = r_sync_auto[1];
  assign w_dir  = r_sync_dir[1];
  assign w_tick = (r_state == AUTO_RUN) && (r_pre == PRE_MAX);

  // A press colliding with a tick pauses instead of stepping
  always_comb begin
    w_step = 1'b0;
    case (r_state)
      MANUAL:   w_step = w_press;
      AUTO_RUN: w_step = w_tick && !w_press;
      default:  w_step = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= MANUAL;
      r_pre        <= '0;
      r_addr       <= '0;
      r_d_out      <= 1'b0;
      r_step_pulse <= 1'b0;
    end else begin
      r_d_out      <= r_sync_d[1];
      r_step_pulse <= w_step;
      if (w_step) begin
        r_addr <= w_dir ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
      end

      // Prescaler clears on every exit from AUTO_RUN so re-entry gets a full period
      case (r_state)
        MANUAL: begin
          r_pre <= '0;
          if (w_auto) r_state <= AUTO_RUN;
        end
        AUTO_RUN: begin
          if (!w_auto) begin
            r_state <= MANUAL;
            r_pre   <= '0;
          end else if (w_press) begin
            r_state <= AUTO_PAUSE;
            r_pre   <= '0;
          end else begin
            r_pre <= w_tick ? '0 : (r_pre + PRE_W'(1));
          end
        end
        AUTO_PAUSE: begin
          r_pre <= '0;
          if (!w_auto)     r_state <= MANUAL;
          else if (w_press) r_state <= AUTO_RUN;
        end
        default: begin
          r_state <= MANUAL;
          r_pre   <= '0;
        end
      endcase
    end
  end

  assign bus.addr       = r_addr;
  assign bus.d_out      = r_d_out;
  assign bus.step_pulse = r_step_pulse;

endmodule

// File: tb/tb_demux_addr_scanner.sv
// tb/tb_demux_addr_scanner.sv - scoreboarded bench for demux_addr_scanner
module tb_demux_addr_scanner;

  typedef struct {
    logic [2:0] a;
    int         c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [2:0] exp_addr;

  demux_addr_scanner_if bus();

  demux_addr_scanner #(
    .CLK_HZ  (1000),
    .DEB_MS  (4),
    .STEP_HZ (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d at cyc %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_step(input int lat);
    exp_t e;
    exp_addr = bus.sw_dir ? exp_addr - 3'd1 : exp_addr + 3'd1;
    e.a = exp_addr;
    e.c = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic press_manual();
    push_step(7);
    bus.btn_step = 1'b1;
    wait_cyc(8);
    bus.btn_step = 1'b0;
    wait_cyc(8);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.step_pulse) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_step", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("step_addr", int'(bus.addr), int'(e.a));
        check_val("step_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    int c0;
    rst_n        = 1'b0;
    bus.btn_step = 1'b0;
    bus.sw_auto  = 1'b0;
    bus.sw_dir   = 1'b0;
    bus.sw_d     = 1'b0;
    exp_addr     = 3'd0;
    wait_cyc(3);
    check_val("rst_addr", int'(bus.addr), 0);
    check_val("rst_d_out", int'(bus.d_out), 0);
    check_val("rst_step_pulse", int'(bus.step_pulse), 0);
    rst_n = 1'b1;
    wait_cyc(3);

    // manual step with a long hold: exactly one step
    push_step(7);
    bus.btn_step = 1'b1;
    wait_cyc(6);
    check_val("pre_step_addr", int'(bus.addr), 0);
    wait_cyc(14);
    check_val("held_addr", int'(bus.addr), 1);
    bus.btn_step = 1'b0;
    wait_cyc(10);

    // bounce: 2-cycle toggles never settle long enough
    for (int i = 0; i < 15; i++) begin
      bus.btn_step = ~bus.btn_step;
      wait_cyc(2);
    end
    bus.btn_step = 1'b0;
    wait_cyc(10);
    check_val("bounce_addr", int'(bus.addr), 1);

    // count down through the wrap
    bus.sw_dir = 1'b1;
    wait_cyc(4);
    press_manual();
    press_manual();
    check_val("wrap_down_addr", int'(bus.addr), 7);
    press_manual();
    check_val("down_addr", int'(bus.addr), 6);

    // auto run counting up through 7 -> 0
    bus.sw_dir = 1'b0;
    wait_cyc(4);
    c0 = cyc;
    bus.sw_auto = 1'b1;
    push_step(13);
    push_step(23);
    push_step(33);
    wait_cyc(36);

    // press lands on the same cycle as the tick
    bus.btn_step = 1'b1;
    wait_cyc(8);
    bus.btn_step = 1'b0;
    wait_cyc(42);
    check_val("pause_addr", int'(bus.addr), 1);
    check_val("pause_span", cyc - c0, 86);

    // resume: first step one full period after the press takes effect
    push_step(17);
    bus.btn_step = 1'b1;
    wait_cyc(8);
    bus.btn_step = 1'b0;
    wait_cyc(10);
    bus.btn_step = 1'b1;
    wait_cyc(8);
    bus.btn_step = 1'b0;
    wait_cyc(10);
    check_val("repause_addr", int'(bus.addr), 2);

    // leave auto while paused; presses must step immediately again
    bus.sw_auto = 1'b0;
    wait_cyc(5);
    press_manual();
    press_manual();
    press_manual();
    check_val("manual_again_addr", int'(bus.addr), 5);
    bus.sw_d = 1'b1;
    wait_cyc(4);
    check_val("d_out_high", int'(bus.d_out), 1);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_addr", int'(bus.addr), 0);
    check_val("async_d_out", int'(bus.d_out), 0);
    check_val("async_step_pulse", int'(bus.step_pulse), 0);
    wait_cyc(2);
    rst_n = 1'b1;
    exp_addr = 3'd0;
    @(posedge clk);
    #1 check_val("d_out_after_rst", int'(bus.d_out), 0);
    wait_cyc(4);
    check_val("d_out_resync", int'(bus.d_out), 1);
    check_val("addr_after_rst", int'(bus.addr), 0);
    check_val("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
